// File: rtl/vga_pattern_sequencer_if.sv
// Pixel-path bundle between the VGA timing generator and the pattern sequencer.
// master drives timing/controls and receives RGB; slave is the sequencer.
interface vga_pattern_sequencer_if;
    logic       DE;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic       btn_next;
    logic       auto_en;
    logic [3:0] bar_r;
    logic [3:0] bar_g;
    logic [3:0] bar_b;
    logic [3:0] r_port;
    logic [3:0] g_port;
    logic [3:0] b_port;
    logic       de_out;
    logic [1:0] pattern_id;

    modport master (
        output DE, x_pixel, y_pixel, btn_next, auto_en,
        output bar_r, bar_g, bar_b,
        input  r_port, g_port, b_port, de_out, pattern_id
    );

    modport slave (
        input  DE, x_pixel, y_pixel, btn_next, auto_en,
        input  bar_r, bar_g, bar_b,
        output r_port, g_port, b_port, de_out, pattern_id
    );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern scheduler for the 640x480 VGA path.
// Pattern changes only at end of frame; RGB is registered with blanking.
module vga_pattern_sequencer #(
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int V_ACTIVE           = 480
) (
    input logic                    clk,
    input logic                    reset,
    vga_pattern_sequencer_if.slave bus
);

    localparam logic [9:0] CNT_LAST = 10'(FRAMES_PER_PATTERN - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_ACTIVE - 1);

    typedef enum logic {RUN, PEND} state_t;

    state_t     state_q, state_d;
    logic [9:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] pattern_q, pattern_d;
    logic       de_q;
    logic [9:0] y_q;
    logic [11:0] rgb_q, rgb_d;
    logic       de_out_q;
    logic       eof;
    logic       cnt_last;
    logic       adv;

    // Only a falling DE on the last active line marks end of frame.
    assign eof      = de_q & ~bus.DE & (y_q == Y_LAST);
    assign cnt_last = (frame_cnt_q == CNT_LAST);

    // Previous-cycle DE and row, used for end-of-frame detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q <= 1'b0;
            y_q  <= '0;
        end else begin
            de_q <= bus.DE;
            y_q  <= bus.y_pixel;
        end
    end

    // Next-state logic: a request parks in PEND until the next eof.
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (eof && bus.auto_en && cnt_last) adv = 1'b1;
                if (bus.btn_next) state_d = PEND;
            end
            PEND: begin
                if (eof) begin
                    adv     = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Frame counter and pattern index follow the advance decision.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        pattern_d   = pattern_q;
        if (adv) begin
            frame_cnt_d = '0;
            pattern_d   = pattern_q + 2'd1;
        end else if (eof) begin
            frame_cnt_d = cnt_last ? '0 : frame_cnt_q + 10'd1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            frame_cnt_q <= '0;
            pattern_q   <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            pattern_q   <= pattern_d;
        end
    end

    // Pattern generation from the current pixel, blanked outside DE.
    always_comb begin
        rgb_d = '0;
        unique case (pattern_q)
            2'd0: rgb_d = {bus.bar_r, bus.bar_g, bus.bar_b};
            2'd1: rgb_d = (bus.x_pixel[5] ^ bus.y_pixel[5]) ? 12'hFFF : 12'h000;
            2'd2: rgb_d = {3{bus.x_pixel[9:6]}};
            2'd3: begin
                unique case (bus.y_pixel[8:7])
                    2'd0: rgb_d = 12'hF00;
                    2'd1: rgb_d = 12'h0F0;
                    2'd2: rgb_d = 12'h00F;
                    2'd3: rgb_d = 12'hFFF;
                    default: rgb_d = '0;
                endcase
            end
            default: rgb_d = '0;
        endcase
        if (!bus.DE) rgb_d = '0;
    end

    // One-clock pixel pipeline to the DAC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q    <= '0;
            de_out_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            de_out_q <= bus.DE;
        end
    end

    assign bus.r_port     = rgb_q[11:8];
    assign bus.g_port     = rgb_q[7:4];
    assign bus.b_port     = rgb_q[3:0];
    assign bus.de_out     = de_out_q;
    assign bus.pattern_id = pattern_q;

    logic unused_bits;
    assign unused_bits = ^{bus.x_pixel[4:0]};

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed self-checking bench for vga_pattern_sequencer.
// Uses a compressed frame: a few pixels on lines 0, 100 and 479.
module tb_vga_pattern_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    vga_pattern_sequencer_if vif();

    vga_pattern_sequencer #(
        .FRAMES_PER_PATTERN(3),
        .V_ACTIVE(480)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(vif.slave)
    );

    always #5 clk = ~clk;

    wire [11:0] rgb = {vif.r_port, vif.g_port, vif.b_port};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic de, input logic [9:0] x, input logic [9:0] y);
        vif.DE      = de;
        vif.x_pixel = x;
        vif.y_pixel = y;
        step();
    endtask

    // Compressed frame; eof is the last pix call, so pattern_id is new on return.
    task automatic frame(input logic btn);
        pix(1'b1, 10'd0, 10'd0);
        pix(1'b0, 10'd0, 10'd0);
        vif.btn_next = btn;
        pix(1'b1, 10'd0, 10'd100);
        vif.btn_next = 1'b0;
        pix(1'b0, 10'd0, 10'd100);
        pix(1'b1, 10'd0, 10'd479);
        pix(1'b0, 10'd0, 10'd479);
    endtask

    task automatic do_reset();
        vif.DE       = 1'b0;
        vif.btn_next = 1'b0;
        reset        = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        vif.auto_en = 1'b0;
        vif.bar_r   = 4'hA;
        vif.bar_g   = 4'h5;
        vif.bar_b   = 4'h3;
        vif.x_pixel = '0;
        vif.y_pixel = '0;
        vif.DE      = 1'b1;
        vif.btn_next = 1'b0;
        reset = 1'b1;
        step();
        step();
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb got=%h exp=000", rgb);
        end
        checks++;
        if (vif.de_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_de_out got=%b exp=0", vif.de_out);
        end
        checks++;
        if (vif.pattern_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_pid got=%0d exp=0", vif.pattern_id);
        end
        vif.DE = 1'b0;
        reset  = 1'b0;
        step();
    endtask

    task automatic test_passthrough();
        pix(1'b1, 10'd10, 10'd0);
        checks++;
        if (rgb !== 12'hA53 || vif.de_out !== 1'b1) begin
            errors++;
            $display("FAIL pass_active got=%h/%b exp=A53/1", rgb, vif.de_out);
        end
        pix(1'b0, 10'd10, 10'd0);
        checks++;
        if (rgb !== 12'h000 || vif.de_out !== 1'b0) begin
            errors++;
            $display("FAIL pass_blank got=%h/%b exp=000/0", rgb, vif.de_out);
        end
        pix(1'b1, 10'd0, 10'd479);
        pix(1'b0, 10'd0, 10'd479);
        checks++;
        if (vif.pattern_id !== 2'd0) begin
            errors++;
            $display("FAIL pass_pid got=%0d exp=0", vif.pattern_id);
        end
    endtask

    task automatic test_btn_next();
        pix(1'b1, 10'd0, 10'd0);
        pix(1'b0, 10'd0, 10'd0);
        vif.btn_next = 1'b1;
        pix(1'b1, 10'd5, 10'd100);
        vif.btn_next = 1'b0;
        pix(1'b0, 10'd5, 10'd100);
        pix(1'b1, 10'd0, 10'd479);
        checks++;
        if (vif.pattern_id !== 2'd0) begin
            errors++;
            $display("FAIL btn_before_eof got=%0d exp=0", vif.pattern_id);
        end
        pix(1'b0, 10'd0, 10'd479);
        checks++;
        if (vif.pattern_id !== 2'd1) begin
            errors++;
            $display("FAIL btn_after_eof got=%0d exp=1", vif.pattern_id);
        end
        pix(1'b1, 10'd32, 10'd0);
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL checker_32_0 got=%h exp=FFF", rgb);
        end
        pix(1'b1, 10'd0, 10'd0);
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL checker_0_0 got=%h exp=000", rgb);
        end
        pix(1'b1, 10'd32, 10'd32);
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL checker_32_32 got=%h exp=000", rgb);
        end
        pix(1'b0, 10'd0, 10'd0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            vif.btn_next = 1'b1;
            pix(1'b1, 10'(i), 10'd50);
            vif.btn_next = 1'b0;
            pix(1'b0, 10'd0, 10'd50);
        end
        pix(1'b1, 10'd0, 10'd479);
        pix(1'b0, 10'd0, 10'd479);
        checks++;
        if (vif.pattern_id !== 2'd2) begin
            errors++;
            $display("FAIL multi_btn got=%0d exp=2", vif.pattern_id);
        end
        frame(1'b0);
        checks++;
        if (vif.pattern_id !== 2'd2) begin
            errors++;
            $display("FAIL no_queue got=%0d exp=2", vif.pattern_id);
        end
        pix(1'b1, 10'd0, 10'd0);
        pix(1'b1, 10'd0, 10'd479);
        vif.btn_next = 1'b1;
        pix(1'b0, 10'd0, 10'd479);
        vif.btn_next = 1'b0;
        checks++;
        if (vif.pattern_id !== 2'd2) begin
            errors++;
            $display("FAIL btn_on_eof_now got=%0d exp=2", vif.pattern_id);
        end
        frame(1'b0);
        checks++;
        if (vif.pattern_id !== 2'd3) begin
            errors++;
            $display("FAIL btn_on_eof_next got=%0d exp=3", vif.pattern_id);
        end
    endtask

    task automatic test_patterns();
        pix(1'b1, 10'd0, 10'd128);
        checks++;
        if (rgb !== 12'h0F0) begin
            errors++;
            $display("FAIL band_y128 got=%h exp=0F0", rgb);
        end
        pix(1'b1, 10'd0, 10'd479);
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL band_y479 got=%h exp=FFF", rgb);
        end
        pix(1'b1, 10'd0, 10'd0);
        checks++;
        if (rgb !== 12'hF00) begin
            errors++;
            $display("FAIL band_y0 got=%h exp=F00", rgb);
        end
        pix(1'b1, 10'd0, 10'd256);
        checks++;
        if (rgb !== 12'h00F) begin
            errors++;
            $display("FAIL band_y256 got=%h exp=00F", rgb);
        end
        pix(1'b0, 10'd0, 10'd256);
        frame(1'b1);
        checks++;
        if (vif.pattern_id !== 2'd0) begin
            errors++;
            $display("FAIL wrap_3_to_0 got=%0d exp=0", vif.pattern_id);
        end
        frame(1'b1);
        frame(1'b1);
        pix(1'b1, 10'd64, 10'd7);
        checks++;
        if (rgb !== 12'h111) begin
            errors++;
            $display("FAIL ramp_x64 got=%h exp=111", rgb);
        end
        pix(1'b1, 10'd639, 10'd7);
        checks++;
        if (rgb !== 12'h999) begin
            errors++;
            $display("FAIL ramp_x639 got=%h exp=999", rgb);
        end
        pix(1'b1, 10'd63, 10'd7);
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL ramp_x63 got=%h exp=000", rgb);
        end
        pix(1'b0, 10'd0, 10'd7);
    endtask

    task automatic test_auto();
        logic [1:0] exp_pid [12];
        exp_pid = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                    2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        do_reset();
        vif.auto_en = 1'b1;
        for (int f = 0; f < 12; f++) begin
            frame(1'b0);
            checks++;
            if (vif.pattern_id !== exp_pid[f]) begin
                errors++;
                $display("FAIL auto_frame%0d got=%0d exp=%0d",
                         f + 1, vif.pattern_id, exp_pid[f]);
            end
        end
        frame(1'b0);
        frame(1'b1);
        checks++;
        if (vif.pattern_id !== 2'd1) begin
            errors++;
            $display("FAIL auto_btn_adv got=%0d exp=1", vif.pattern_id);
        end
        frame(1'b0);
        frame(1'b0);
        checks++;
        if (vif.pattern_id !== 2'd1) begin
            errors++;
            $display("FAIL auto_cnt_restart got=%0d exp=1", vif.pattern_id);
        end
        frame(1'b0);
        checks++;
        if (vif.pattern_id !== 2'd2) begin
            errors++;
            $display("FAIL auto_after_restart got=%0d exp=2", vif.pattern_id);
        end
        frame(1'b0);
        frame(1'b0);
        frame(1'b1);
        checks++;
        if (vif.pattern_id !== 2'd3) begin
            errors++;
            $display("FAIL auto_btn_coincide got=%0d exp=3", vif.pattern_id);
        end
        frame(1'b0);
        checks++;
        if (vif.pattern_id !== 2'd3) begin
            errors++;
            $display("FAIL auto_coincide_hold got=%0d exp=3", vif.pattern_id);
        end
        vif.auto_en = 1'b0;
    endtask

    task automatic test_reset_pend();
        do_reset();
        vif.auto_en = 1'b0;
        frame(1'b1);
        frame(1'b1);
        vif.btn_next = 1'b1;
        pix(1'b1, 10'd0, 10'd50);
        vif.btn_next = 1'b0;
        pix(1'b1, 10'd64, 10'd50);
        checks++;
        if (rgb !== 12'h111 || vif.pattern_id !== 2'd2) begin
            errors++;
            $display("FAIL pend_setup got=%h/%0d exp=111/2", rgb, vif.pattern_id);
        end
        vif.y_pixel = 10'd479;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rgb !== 12'h000 || vif.de_out !== 1'b0 || vif.pattern_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got=%h/%b/%0d exp=000/0/0",
                     rgb, vif.de_out, vif.pattern_id);
        end
        step();
        step();
        vif.DE = 1'b0;
        reset  = 1'b0;
        step();
        checks++;
        if (vif.pattern_id !== 2'd0) begin
            errors++;
            $display("FAIL release_no_eof got=%0d exp=0", vif.pattern_id);
        end
        frame(1'b0);
        checks++;
        if (vif.pattern_id !== 2'd0) begin
            errors++;
            $display("FAIL pend_discarded got=%0d exp=0", vif.pattern_id);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_btn_next();
        test_back_to_back();
        test_patterns();
        test_auto();
        test_reset_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
